// File: rtl/execute_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing and hazard controller.
package execute_ctrl_pkg;

  localparam int RA_W = 5;

  // Operand source selects driven to the execute stage.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // MEM stage: only what forwarding needs to see.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } stage_t;

  // EX stage: destination tracking plus sources and decoded execute controls.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic            reg_write;
    logic            mem_read;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic            ext_op;
  } ex_stage_t;

  // A bubble is the all-zero stage: invalid, writes nothing, rd/rs/rt = r0.
  localparam stage_t    STAGE_BUBBLE = '0;
  localparam ex_stage_t EX_BUBBLE    = '0;

endpackage

// File: rtl/execute_ctrl_if.sv
// ID-side inputs and execute-side outputs of the execute controller.
// Handshake: i_id_valid=1 offers an instruction in ID; it is taken on a rising
// edge where o_stall=0 and i_flush=0. While o_stall=1 the producer must keep
// the same ID instruction presented.
interface execute_ctrl_if #(
  parameter int CNT_W = 16
);
  import execute_ctrl_pkg::*;

  logic            i_id_valid;
  logic [RA_W-1:0] i_id_rs;
  logic [RA_W-1:0] i_id_rt;
  logic            i_id_useRs;
  logic            i_id_useRt;
  logic [RA_W-1:0] i_id_rd;
  logic            i_id_regWrite;
  logic            i_id_memRead;
  logic            i_id_ALUSrc;
  logic [1:0]      i_id_ALUop;
  logic            i_id_extOp;
  logic            i_hold;
  logic            i_flush;

  logic             o_ALUSrc;
  logic [1:0]       o_ALUop;
  logic             o_extOp;
  logic [1:0]       o_fwdA;
  logic [1:0]       o_fwdB;
  logic             o_stall;
  logic [RA_W-1:0]  o_ex_rd;
  logic [RA_W-1:0]  o_mem_rd;
  logic [RA_W-1:0]  o_wb_rd;
  logic             o_mem_regWrite;
  logic             o_wb_regWrite;
  logic             o_mem_memRead;
  logic [CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_id_valid, i_id_rs, i_id_rt, i_id_useRs, i_id_useRt, i_id_rd,
           i_id_regWrite, i_id_memRead, i_id_ALUSrc, i_id_ALUop, i_id_extOp,
           i_hold, i_flush,
    input  o_ALUSrc, o_ALUop, o_extOp, o_fwdA, o_fwdB, o_stall, o_ex_rd,
           o_mem_rd, o_wb_rd, o_mem_regWrite, o_wb_regWrite, o_mem_memRead,
           o_stall_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs, i_id_rt, i_id_useRs, i_id_useRt, i_id_rd,
           i_id_regWrite, i_id_memRead, i_id_ALUSrc, i_id_ALUop, i_id_extOp,
           i_hold, i_flush,
    output o_ALUSrc, o_ALUop, o_extOp, o_fwdA, o_fwdB, o_stall, o_ex_rd,
           o_mem_rd, o_wb_rd, o_mem_regWrite, o_wb_regWrite, o_mem_memRead,
           o_stall_cnt
  );

endinterface

// File: rtl/execute_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register.
module execute_ctrl_fwd_unit
  import execute_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  output logic [1:0]      sel
);

  // MEM wins over WB; a load in MEM has no data yet so it never forwards from MEM.
  always_comb begin
    sel = FWD_RF;
    if (use_src && src != '0) begin
      if (mem_reg_write && !mem_mem_read && mem_rd == src) begin
        sel = FWD_MEM;
      end else if (wb_reg_write && wb_rd == src) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/execute_ctrl.sv
// ID/EX sequencing and hazard control: EX/MEM/WB destination tracking,
// operand forwarding, load-use bubble insertion and a stall-cycle counter.
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  execute_ctrl_if.slave  bus
);

  ex_stage_t        ex;
  stage_t           mem;
  logic             wb_valid;
  logic [RA_W-1:0]  wb_rd;
  logic             wb_reg_write;
  logic [CNT_W-1:0] stall_cnt;
  ex_stage_t        id_ex;
  logic             hazard;

  // ID fields gated by i_id_valid so an empty ID slot becomes a clean bubble.
  always_comb begin
    id_ex = EX_BUBBLE;
    if (bus.i_id_valid) begin
      id_ex.valid     = 1'b1;
      id_ex.rd        = bus.i_id_rd;
      id_ex.rs        = bus.i_id_rs;
      id_ex.rt        = bus.i_id_rt;
      id_ex.use_rs    = bus.i_id_useRs;
      id_ex.use_rt    = bus.i_id_useRt;
      id_ex.reg_write = bus.i_id_regWrite;
      id_ex.mem_read  = bus.i_id_memRead;
      id_ex.alu_src   = bus.i_id_ALUSrc;
      id_ex.alu_op    = bus.i_id_ALUop;
      id_ex.ext_op    = bus.i_id_extOp;
    end
  end

  // Load in EX whose (non-r0) result is read by a live, non-flushed ID instruction.
  always_comb begin
    hazard = ex.valid && ex.mem_read && (ex.rd != '0) &&
             ((bus.i_id_useRs && bus.i_id_rs == ex.rd) ||
              (bus.i_id_useRt && bus.i_id_rt == ex.rd)) &&
             bus.i_id_valid && !bus.i_flush;
  end

  // Pipeline advance unless held; flush or hazard turns the EX load into a bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex           <= EX_BUBBLE;
      mem          <= STAGE_BUBBLE;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      stall_cnt    <= '0;
    end else if (!bus.i_hold) begin
      wb_valid     <= mem.valid;
      wb_rd        <= mem.rd;
      wb_reg_write <= mem.reg_write;
      mem.valid     <= ex.valid;
      mem.rd        <= ex.rd;
      mem.reg_write <= ex.reg_write;
      mem.mem_read  <= ex.mem_read;
      if (bus.i_flush || hazard) begin
        ex <= EX_BUBBLE;
      end else begin
        ex <= id_ex;
      end
      if (hazard && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  execute_ctrl_fwd_unit u_fwd_a (
    .src           (ex.rs),
    .use_src       (ex.use_rs),
    .mem_rd        (mem.rd),
    .mem_reg_write (mem.valid && mem.reg_write),
    .mem_mem_read  (mem.mem_read),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_valid && wb_reg_write),
    .sel           (bus.o_fwdA)
  );

  execute_ctrl_fwd_unit u_fwd_b (
    .src           (ex.rt),
    .use_src       (ex.use_rt),
    .mem_rd        (mem.rd),
    .mem_reg_write (mem.valid && mem.reg_write),
    .mem_mem_read  (mem.mem_read),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_valid && wb_reg_write),
    .sel           (bus.o_fwdB)
  );

  assign bus.o_ALUSrc       = ex.alu_src;
  assign bus.o_ALUop        = ex.alu_op;
  assign bus.o_extOp        = ex.ext_op;
  assign bus.o_stall        = bus.i_hold || hazard;
  assign bus.o_ex_rd        = ex.rd;
  assign bus.o_mem_rd       = mem.rd;
  assign bus.o_wb_rd        = wb_rd;
  assign bus.o_mem_regWrite = mem.reg_write;
  assign bus.o_wb_regWrite  = wb_reg_write;
  assign bus.o_mem_memRead  = mem.mem_read;
  assign bus.o_stall_cnt    = stall_cnt;

endmodule

// File: doc/execute_ctrl.md
Name: execute_ctrl

Overview:
- ID/EX sequencing and hazard controller for the execute stage.
- Registers decoded control for execute: ALU source select, ALU op and extender op.
- Tracks destination registers through the EX, MEM and WB stages.
- Drives forwarding selects for both execute operands, detects load-use hazards, injects bubbles, and counts stall cycles for performance debug.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs, i_id_rt  in  RA_W  source registers of the ID instruction.
- i_id_useRs, i_id_useRt  in  1  the ID instruction actually reads rs / rt.
- i_id_rd  in  RA_W  destination register of the ID instruction.
- i_id_regWrite, i_id_memRead  in  1  ID instruction writes the register file / is a load.
- i_id_ALUSrc  in  1  decoded ALU source select.
- i_id_ALUop  in  2  decoded ALU op.
- i_id_extOp  in  1  decoded extender op.
- i_hold  in  1  external freeze (memory wait).
- i_flush  in  1  taken branch; ID instruction is wrong-path.
- o_ALUSrc, o_ALUop[1:0], o_extOp  out  1/2/1  registered controls to execute.
- o_fwdA, o_fwdB  out  2  operand select: 00 register file, 01 MEM ALU result, 10 WB result.
- o_stall  out  1  hold PC and IF/ID this cycle.
- o_ex_rd, o_mem_rd, o_wb_rd  out  RA_W  stage destination registers.
- o_mem_regWrite, o_wb_regWrite, o_mem_memRead  out  1  stage controls.
- o_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async, i_rst=1): every stage register is set to bubble (valid=0, regWrite=0, memRead=0, rd=0, rs=0, rt=0). All control outputs are 0, o_fwdA=o_fwdB=00, o_stall=0, o_stall_cnt=0.
- Each stage register holds: valid, rd, regWrite, memRead. EX additionally holds rs, rt, useRs, useRt, ALUSrc, ALUop, extOp.
- Advance: on every edge with i_hold=0, MEM<=EX and WB<=MEM. EX loads according to the following priority:
  - i_flush=1: EX<=bubble.
  - load-use hazard: EX<=bubble.
  - otherwise: EX<=ID, with fields gated by i_id_valid; invalid ID loads a bubble.
- Hold: i_hold=1 freezes every register and o_stall_cnt. o_stall=1 while i_hold=1. i_flush is ignored while held; the requester keeps i_flush asserted until i_hold drops.
- Load-use hazard (combinational from ID and EX): all of the following must be true:
  - EX.valid and EX.memRead;
  - EX.rd != 0;
  - (i_id_useRs and i_id_rs==EX.rd) or (i_id_useRt and i_id_rt==EX.rd);
  - i_id_valid and not i_flush.
- o_stall = i_hold | hazard. A hazard produces exactly one bubble, after which the load reaches MEM and is forwarded from WB.
- Forwarding (combinational from EX, MEM and WB registers), operand A shown; B is identical with rt/useRt:
  - 01 if MEM.regWrite and MEM.rd!=0 and MEM.rd==EX.rs and EX.useRs.
  - else 10 if WB.regWrite and WB.rd!=0 and WB.rd==EX.rs and EX.useRs.
  - else 00.
  - MEM has priority over WB.
  - A load in MEM is never forwarded from MEM (MEM.memRead masks the 01 case); hazard logic guarantees it is not needed.
- Register 0 never forwards and never stalls.
- o_stall_cnt increments on each edge where the hazard is true and i_hold=0. It saturates at all-ones and does not wrap.
- Outputs o_ALUSrc/o_ALUop/o_extOp come directly from EX registers, so a bubble drives 0.

Decomposition:
- Shared package holds:
  - forwarding select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - RA_W;
  - bubble field values.
- One sub-module, fwd_unit: purely combinational, compares one EX source against MEM/WB and returns a 2-bit select. Instantiated twice, for A and B.

Test Plan:
- Reset mid-stream: assert i_rst while EX/MEM/WB are valid -> all outputs 0 immediately (async), o_stall_cnt=0.
- Back-to-back ALU ops: add r3 then sub using rs=r3 -> o_fwdA=01 in the second instruction's EX cycle. With one unrelated instruction between them -> o_fwdA=10.
- Load-use: lw r5 then add rs=r5 -> o_stall=1 for exactly one cycle and EX bubble (o_ALUop=0). Next cycle o_fwdA=10 and o_stall_cnt=1.
- r0 destination: lw r0 followed by use of r0 -> no stall, fwd=00. Non-used rt equal to EX.rd (useRt=0) -> no stall.
- Flush during a hazard: i_flush=1 with a load-use condition present -> o_stall=0, EX bubble, counter unchanged.
- Hold: i_hold=1 for 3 cycles during a hazard -> all stage registers and counter frozen, o_stall=1. Release -> a single bubble is inserted and the counter increments by 1. Separately, force 2^CNT_W+5 hazards -> counter stays at all-ones.
